// File: rtl/bomb_sprite_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : bomb_sprite_mixer
//  Description : Single-bomb sprite overlay between the VGA timing generator
//                and the RGB output. Holds one bomb on a 40x30 grid of 16 px
//                cells, runs the fuse/blast lifecycle counted in frames, feeds
//                the scan position to the 16x16 bomb image ROM, delays the
//                background to match the ROM read latency, and keys out
//                transparent sprite pixels.
//  Ports       : i_clk, i_rst          pixel clock, async active-high reset
//                i_frame_tick          one pulse per frame (in blanking)
//                i_place, i_cell_*     bomb placement request
//                i_pos_*, i_de, i_bg_rgb  scan position / background pixel
//                o_rom_pos_*           scan position passed to the ROM
//                i_rom_data            ROM pixel, 1 cycle after address
//                o_rgb, o_de           final pixel, 2 cycles after i_pos
//                o_active, o_explode   lifecycle status / blast-entry pulse
//                o_bomb_cell_*         latched bomb cell
//  Revision    : 1.0 - initial release
// ============================================================================
module bomb_sprite_mixer #(
    parameter int          FUSE_FRAMES  = 180,
    parameter int          BLINK_FRAMES = 60,
    parameter int          BLINK_SHIFT  = 3,
    parameter int          BLAST_FRAMES = 30,
    parameter logic [23:0] KEY_RGB      = 24'h000000,
    parameter logic [23:0] BLAST_RGB    = 24'hFF0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_frame_tick,
    input  logic        i_place,
    input  logic [5:0]  i_cell_x,
    input  logic [4:0]  i_cell_y,
    input  logic [9:0]  i_pos_x,
    input  logic [9:0]  i_pos_y,
    input  logic        i_de,
    input  logic [23:0] i_bg_rgb,
    output logic [9:0]  o_rom_pos_x,
    output logic [9:0]  o_rom_pos_y,
    input  logic [23:0] i_rom_data,
    output logic [23:0] o_rgb,
    output logic        o_de,
    output logic        o_active,
    output logic        o_explode,
    output logic [5:0]  o_bomb_cell_x,
    output logic [4:0]  o_bomb_cell_y
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ARMED = 2'd1;
    localparam logic [1:0] c_ST_BLAST = 2'd2;

    localparam logic [7:0] c_FUSE_LAST   = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0] c_BLAST_LAST  = 8'(BLAST_FRAMES - 1);
    // First fuse count at which the blink phase starts to matter.
    localparam logic [7:0] c_BLINK_START = 8'(FUSE_FRAMES - BLINK_FRAMES);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [5:0]  r_cell_x;
    logic [4:0]  r_cell_y;
    logic        r_active;
    logic        r_explode;

    logic        r_hit1;
    logic        r_de1;
    logic [23:0] r_bg1;
    logic [23:0] r_rgb;
    logic        r_de2;

    logic        w_place_ok;
    logic        w_vis;
    logic        w_hit;
    logic        w_blast;

    assign o_rom_pos_x = i_pos_x;
    assign o_rom_pos_y = i_pos_y;

    assign w_place_ok = i_place && (i_cell_x < 6'd40) && (i_cell_y < 5'd30);

    // ------------------------------------------------------------------------
    // Lifecycle FSM. Transitions only on a frame tick or a place, both of
    // which arrive during blanking, so the sprite never changes mid-frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= 8'd0;
            r_cell_x  <= 6'd0;
            r_cell_y  <= 5'd0;
            r_active  <= 1'b0;
            r_explode <= 1'b0;
        end else begin
            r_explode <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    // A place beats a coincident tick: the count starts at 0.
                    if (w_place_ok) begin
                        r_state  <= c_ST_ARMED;
                        r_cell_x <= i_cell_x;
                        r_cell_y <= i_cell_y;
                        r_cnt    <= 8'd0;
                        r_active <= 1'b1;
                    end
                end
                c_ST_ARMED: begin
                    if (i_frame_tick) begin
                        if (r_cnt == c_FUSE_LAST) begin
                            r_state   <= c_ST_BLAST;
                            r_cnt     <= 8'd0;
                            r_explode <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                c_ST_BLAST: begin
                    if (i_frame_tick) begin
                        if (r_cnt == c_BLAST_LAST) begin
                            r_state  <= c_ST_IDLE;
                            r_cnt    <= 8'd0;
                            r_active <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    r_state  <= c_ST_IDLE;
                    r_cnt    <= 8'd0;
                    r_active <= 1'b0;
                end
            endcase
        end
    end

    assign w_blast = (r_state == c_ST_BLAST);

    // Blinking only applies inside the final part of the fuse.
    assign w_vis = w_blast ||
                   ((r_state == c_ST_ARMED) &&
                    ((r_cnt < c_BLINK_START) || !r_cnt[BLINK_SHIFT]));

    // Raw position compare; the ROM handles its own address mapping.
    assign w_hit = i_de && w_vis &&
                   (i_pos_x[9:4] == r_cell_x) &&
                   (i_pos_y[9:4] == {1'b0, r_cell_y});

    // ------------------------------------------------------------------------
    // Two-stage pixel pipeline. Stage 1 waits out the ROM read latency,
    // stage 2 selects between background, ROM pixel and blast colour.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hit1 <= 1'b0;
            r_de1  <= 1'b0;
            r_bg1  <= 24'd0;
            r_rgb  <= 24'd0;
            r_de2  <= 1'b0;
        end else begin
            r_hit1 <= w_hit;
            r_de1  <= i_de;
            r_bg1  <= i_bg_rgb;
            r_de2  <= r_de1;
            if (!r_de1) begin
                r_rgb <= 24'd0;
            end else if (r_hit1 && (i_rom_data != KEY_RGB)) begin
                r_rgb <= w_blast ? BLAST_RGB : i_rom_data;
            end else begin
                r_rgb <= r_bg1;
            end
        end
    end

    assign o_rgb         = r_rgb;
    assign o_de          = r_de2;
    assign o_active      = r_active;
    assign o_explode     = r_explode;
    assign o_bomb_cell_x = r_cell_x;
    assign o_bomb_cell_y = r_cell_y;

endmodule
`default_nettype wire

// File: tb/tb_bomb_sprite_mixer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bomb_sprite_mixer
//  Description : Self-checking bench for bomb_sprite_mixer. Pixel stimulus
//                is scored through an expectation queue drained by an
//                independent monitor; lifecycle outputs are checked directly
//                against a frame-count reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bomb_sprite_mixer;

    localparam int          FUSE  = 180;
    localparam int          BLINK = 60;
    localparam int          BLAST = 30;
    localparam logic [23:0] KEY   = 24'h000000;
    localparam logic [23:0] BRGB  = 24'hFF0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        frame_tick = 1'b0;
    logic        place = 1'b0;
    logic [5:0]  cell_x = '0;
    logic [4:0]  cell_y = '0;
    logic [9:0]  pos_x = '0;
    logic [9:0]  pos_y = '0;
    logic        de = 1'b0;
    logic [23:0] bg_rgb = '0;
    logic [9:0]  rom_pos_x;
    logic [9:0]  rom_pos_y;
    logic [23:0] rom_data = '0;
    logic [23:0] rgb;
    logic        de_out;
    logic        active;
    logic        explode;
    logic [5:0]  bomb_x;
    logic [4:0]  bomb_y;

    bomb_sprite_mixer dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_frame_tick (frame_tick),
        .i_place      (place),
        .i_cell_x     (cell_x),
        .i_cell_y     (cell_y),
        .i_pos_x      (pos_x),
        .i_pos_y      (pos_y),
        .i_de         (de),
        .i_bg_rgb     (bg_rgb),
        .o_rom_pos_x  (rom_pos_x),
        .o_rom_pos_y  (rom_pos_y),
        .i_rom_data   (rom_data),
        .o_rgb        (rgb),
        .o_de         (de_out),
        .o_active     (active),
        .o_explode    (explode),
        .o_bomb_cell_x(bomb_x),
        .o_bomb_cell_y(bomb_y)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous image ROM model: 1-cycle read latency.
    logic [23:0] rom_tab [256];
    always @(posedge clk) rom_data <= rom_tab[{rom_pos_y[3:0], rom_pos_x[3:0]}];

    // Reference model: bomb life measured in ticks since placement.
    bit m_live  = 0;
    int m_ticks = 0;
    int m_cx    = 0;
    int m_cy    = 0;

    function automatic bit m_blast();
        return m_live && (m_ticks >= FUSE);
    endfunction

    function automatic bit m_visible();
        if (!m_live) return 0;
        if (m_ticks >= FUSE) return 1;
        if (m_ticks < FUSE - BLINK) return 1;
        return ((m_ticks / 8) % 2) == 0;
    endfunction

    typedef struct {
        logic [23:0] rgb;
        logic        de;
        int          due;
    } exp_t;
    exp_t sb[$];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops the expectation due this cycle and compares.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].due == cyc) begin
            exp_t e;
            e = sb.pop_front();
            check("pixel_rgb", rgb, e.rgb);
            check("pixel_de", de_out, e.de);
        end
    end

    // Drive one pixel (at a negedge) and push its expected output.
    task automatic drive_pixel(input int x, input int y, input bit d, input logic [23:0] bg);
        exp_t e;
        logic [23:0] rom;
        bit hit;
        @(negedge clk);
        pos_x  = 10'(x);
        pos_y  = 10'(y);
        de     = d;
        bg_rgb = bg;
        rom = rom_tab[(y % 16) * 16 + (x % 16)];
        hit = d && m_visible() && (x / 16 == m_cx) && (y / 16 == m_cy);
        if (!d)                    e.rgb = 24'd0;
        else if (hit && rom != KEY) e.rgb = m_blast() ? BRGB : rom;
        else                       e.rgb = bg;
        e.de  = d;
        e.due = cyc + 2;
        sb.push_back(e);
    endtask

    // Burst of random pixels, half of them around the bomb cell, then drain.
    task automatic burst(input int n);
        drive_pixel(m_cx * 16, m_cy * 16, 1'b1, 24'h123456);
        for (int i = 0; i < n; i++) begin
            int x, y;
            if ($urandom_range(1, 0) == 1) begin
                x = m_cx * 16 + $urandom_range(23, 0) - 4;
                y = m_cy * 16 + $urandom_range(23, 0) - 4;
                if (x < 0) x = 0;
                if (y < 0) y = 0;
            end else begin
                x = $urandom_range(1023, 0);
                y = $urandom_range(1023, 0);
            end
            drive_pixel(x, y, $urandom_range(7, 0) != 0, 24'($urandom));
        end
        for (int i = 0; i < 3; i++) drive_pixel(0, 0, 1'b0, 24'($urandom));
        @(negedge clk);
    endtask

    // One control cycle: optional place and/or tick, then check lifecycle outputs.
    task automatic ctrl(input bit pl, input int px, input int py, input bit tk);
        bit pulse;
        pulse = 0;
        @(negedge clk);
        de         = 1'b0;
        place      = pl;
        cell_x     = 6'(px);
        cell_y     = 5'(py);
        frame_tick = tk;
        if (pl && !m_live && px < 40 && py < 30) begin
            m_live  = 1;
            m_ticks = 0;
            m_cx    = px;
            m_cy    = py;
        end else if (tk && m_live) begin
            m_ticks++;
            pulse = (m_ticks == FUSE);
            if (m_ticks == FUSE + BLAST) m_live = 0;
        end
        @(negedge clk);
        place      = 1'b0;
        frame_tick = 1'b0;
        check("explode", explode, pulse);
        check("active", active, m_live);
        check("cell_x", bomb_x, m_cx);
        check("cell_y", bomb_y, m_cy);
    endtask

    task automatic tick_to(input int target);
        while (m_live && m_ticks < target) ctrl(0, 0, 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++)
            rom_tab[i] = ($urandom_range(3, 0) == 0) ? KEY : 24'($urandom);
        rom_tab[0] = 24'h00FF00;

        // Reset state, checked while reset is asserted (asynchronous).
        rst = 1'b1;
        #1;
        check("rst_rgb", rgb, 0);
        check("rst_de", de_out, 0);
        check("rst_active", active, 0);
        check("rst_explode", explode, 0);
        check("rst_cell", {bomb_x, bomb_y}, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rom_pass_x", rom_pos_x, pos_x);

        // Idle: no sprite anywhere.
        burst(30);

        // Out-of-range places are ignored.
        ctrl(1, 40, 0, 0);
        ctrl(1, 0, 30, 0);

        // Place (5,3) and scan around it.
        ctrl(1, 5, 3, 0);
        burst(60);
        drive_pixel(96, 48, 1'b1, 24'hABCDEF);
        drive_pixel(80, 48, 1'b0, 24'hABCDEF);
        burst(2);

        // Second place while armed is ignored.
        ctrl(1, 10, 10, 0);

        // Walk through the fuse, probing the blink window.
        tick_to(50);   burst(30);
        tick_to(119);  burst(20);
        tick_to(120);  burst(20);
        tick_to(127);  burst(20);
        tick_to(128);  burst(20);
        tick_to(135);  burst(20);
        tick_to(136);  burst(20);
        tick_to(179);  burst(20);
        tick_to(180);  burst(40);   // blast entry
        ctrl(0, 0, 0, 0);           // pulse is single-cycle
        tick_to(195);  burst(20);
        tick_to(FUSE + BLAST);
        burst(20);                  // idle again, cell held

        // Place together with a tick in idle: count starts from zero.
        ctrl(1, 39, 29, 1);
        tick_to(100);
        burst(20);

        // Reset mid-fuse.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_active", active, 0);
        check("mid_rst_explode", explode, 0);
        check("mid_rst_cell", {bomb_x, bomb_y}, 0);
        check("mid_rst_rgb", rgb, 0);
        @(negedge clk);
        rst = 1'b0;
        m_live = 0; m_ticks = 0; m_cx = 0; m_cy = 0;
        ctrl(0, 0, 0, 1);
        burst(10);

        // A fresh place runs the full fuse again.
        ctrl(1, 0, 0, 0);
        burst(20);
        tick_to(FUSE + 5);
        burst(20);

        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
